// File: rtl/tea_decryptor.sv
// TEA block decryptor: one 64-bit ciphertext in, one 64-bit plaintext out,
// one round per cycle with fixed latency regardless of key or data.
module tea_decryptor #(
    parameter int          ROUNDS = 32,
    parameter logic [31:0] DELTA  = 32'h9E3779B9
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic [127:0]  i_key,
    input  logic          i_axis_valid_s,
    output logic          o_axis_ready_s,
    input  logic [63:0]   i_axis_data_s,
    output logic          o_axis_valid_m,
    input  logic          i_axis_ready_m,
    output logic [63:0]   o_axis_data_m
);

    localparam int          CW       = $clog2(ROUNDS) + 1;
    localparam logic [31:0] SUM_INIT = DELTA * 32'(ROUNDS);

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        LOADING    = 2'd1,
        PROCESSING = 2'd2,
        DONE       = 2'd3
    } state_t;

    state_t          state;
    state_t          state_next;
    logic [CW-1:0]   round_counter;
    logic [31:0]     v0;
    logic [31:0]     v1;
    logic [31:0]     sum;
    logic [127:0]    key_q;
    logic [31:0]     v0_new;
    logic [31:0]     v1_new;
    logic            last_round;
    logic [1:0]      rst_sync;
    logic            rst_n;

    // Reset asserts immediately but releases two clocks after i_rst_n rises.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            rst_sync <= 2'b00;
        end else begin
            rst_sync <= {rst_sync[0], 1'b1};
        end
    end

    assign rst_n = rst_sync[1];

    // One inverse round; v0 is recovered from the freshly recovered v1.
    always_comb begin
        v1_new = v1 - (((v0 << 4) + key_q[63:32]) ^ (v0 + sum) ^ ((v0 >> 5) + key_q[31:0]));
        v0_new = v0 - (((v1_new << 4) + key_q[127:96]) ^ (v1_new + sum) ^ ((v1_new >> 5) + key_q[95:64]));
    end

    assign last_round = (round_counter == CW'(ROUNDS - 1));

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples its inputs from before the edge, independent of block order.
    always_ff @(posedge i_clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // NOTE: each combinational block assigns a default first so no path
    // leaves an output unassigned, which would otherwise infer a latch.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:       if (i_axis_valid_s) state_next = LOADING;
            LOADING:    state_next = PROCESSING;
            PROCESSING: if (last_round) state_next = DONE;
            DONE:       if (i_axis_ready_m) state_next = IDLE;
            default:    state_next = IDLE;
        endcase
    end

    always_comb begin
        o_axis_ready_s = 1'b0;
        o_axis_valid_m = 1'b0;
        case (state)
            IDLE:    o_axis_ready_s = rst_n;
            DONE:    o_axis_valid_m = 1'b1;
            default: ;
        endcase
    end

    // NOTE: the datapath registers are all reset so an aborted block leaves
    // no plaintext or key material behind.
    always_ff @(posedge i_clk or negedge rst_n) begin
        if (!rst_n) begin
            v0            <= '0;
            v1            <= '0;
            sum           <= '0;
            key_q         <= '0;
            round_counter <= '0;
            o_axis_data_m <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (i_axis_valid_s) begin
                        v0    <= i_axis_data_s[63:32];
                        v1    <= i_axis_data_s[31:0];
                        key_q <= i_key;
                    end
                end
                LOADING: begin
                    sum           <= SUM_INIT;
                    round_counter <= '0;
                end
                PROCESSING: begin
                    v0            <= v0_new;
                    v1            <= v1_new;
                    sum           <= sum - DELTA;
                    round_counter <= round_counter + CW'(1);
                    if (last_round) begin
                        o_axis_data_m <= {v0_new, v1_new};
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_tea_decryptor.sv
// Directed bench for tea_decryptor: known answer, round trips against a TEA
// encryption model, constant-time, backpressure, busy input and reset abort.
module tb_tea_decryptor;

    logic          i_clk = 1'b0;
    logic          i_rst_n = 1'b0;
    logic [127:0]  i_key = '0;
    logic          i_axis_valid_s = 1'b0;
    logic          o_axis_ready_s;
    logic [63:0]   i_axis_data_s = '0;
    logic          o_axis_valid_m;
    logic          i_axis_ready_m = 1'b1;
    logic [63:0]   o_axis_data_m;

    int n_assert = 0;
    int n_fail   = 0;

    tea_decryptor dut (
        .i_clk          (i_clk),
        .i_rst_n        (i_rst_n),
        .i_key          (i_key),
        .i_axis_valid_s (i_axis_valid_s),
        .o_axis_ready_s (o_axis_ready_s),
        .i_axis_data_s  (i_axis_data_s),
        .o_axis_valid_m (o_axis_valid_m),
        .i_axis_ready_m (i_axis_ready_m),
        .o_axis_data_m  (o_axis_data_m)
    );

    always #5 i_clk = ~i_clk;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference TEA encryption; decrypting its output must give back the plaintext.
    function automatic logic [63:0] tea_enc(input logic [127:0] k, input logic [63:0] p);
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] s;
        a = p[63:32];
        b = p[31:0];
        s = 32'h0;
        for (int i = 0; i < 32; i++) begin
            s = s + 32'h9E3779B9;
            a = a + ((((b << 4) + k[127:96]) ^ (b + s)) ^ ((b >> 5) + k[95:64]));
            b = b + ((((a << 4) + k[63:32]) ^ (a + s)) ^ ((a >> 5) + k[31:0]));
        end
        return {a, b};
    endfunction

    function automatic logic [127:0] rand_key();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // Entered and left on a falling edge; returns during the LOADING cycle.
    task automatic accept(input logic [127:0] k, input logic [63:0] d, input bit hold_valid);
        bit ok;
        ok = 1'b0;
        i_key = k;
        i_axis_data_s = d;
        i_axis_valid_s = 1'b1;
        for (int i = 0; i < 200; i++) begin
            if (o_axis_ready_s === 1'b1) begin
                @(negedge i_clk);
                ok = 1'b1;
                break;
            end
            @(negedge i_clk);
        end
        if (!hold_valid) i_axis_valid_s = 1'b0;
        check("accept", 128'(ok), 128'd1);
    endtask

    // Counts cycles from acceptance (LOADING cycle = 1) until output valid.
    task automatic wait_result(input bit busy, output int lat, output int proc,
                               output bit seq_ok, output bit busy_ok);
        lat = 1;
        proc = 0;
        seq_ok = 1'b1;
        busy_ok = 1'b1;
        while (o_axis_valid_m !== 1'b1 && lat < 100) begin
            if (dut.state === 2'd2) begin
                if (int'(dut.round_counter) != proc) seq_ok = 1'b0;
                proc++;
            end
            if (busy) begin
                if (o_axis_ready_s !== 1'b0) busy_ok = 1'b0;
                i_key = rand_key();
            end
            @(negedge i_clk);
            lat++;
        end
    endtask

    task automatic run_block(input string tag, input logic [127:0] k,
                             input logic [63:0] ct, input logic [63:0] exp);
        int lat;
        int proc;
        bit seq_ok;
        bit busy_ok;
        accept(k, ct, 1'b0);
        wait_result(1'b0, lat, proc, seq_ok, busy_ok);
        check({tag, "_latency"}, 128'(lat), 128'd34);
        check({tag, "_proc_cycles"}, 128'(proc), 128'd32);
        check({tag, "_counter_seq"}, 128'(seq_ok), 128'd1);
        check({tag, "_data"}, 128'(o_axis_data_m), 128'(exp));
        @(negedge i_clk);
        check({tag, "_valid_drop"}, 128'(o_axis_valid_m), 128'd0);
        check({tag, "_back_idle"}, 128'(dut.state), 128'd0);
    endtask

    initial begin
        logic [127:0] ka;
        logic [127:0] kb;
        logic [63:0]  pa;
        logic [63:0]  pb;
        logic [63:0]  held;
        logic [127:0] ct_keys [3];
        logic [63:0]  ct_data [2];
        int lat;
        int proc;
        bit seq_ok;
        bit busy_ok;
        bit stable;

        // Reset state
        repeat (3) @(negedge i_clk);
        check("rst_ready_s", 128'(o_axis_ready_s), 128'd0);
        check("rst_valid_m", 128'(o_axis_valid_m), 128'd0);
        check("rst_data_m", 128'(o_axis_data_m), 128'd0);
        check("rst_state", 128'(dut.state), 128'd0);
        check("rst_counter", 128'(dut.round_counter), 128'd0);
        i_rst_n = 1'b1;
        repeat (3) @(negedge i_clk);
        check("idle_ready_s", 128'(o_axis_ready_s), 128'd1);

        // Known answer: TEA(key=0, pt=0) = 41EA3A0A_94BAA940
        run_block("kat", 128'h0, 64'h41EA3A0A_94BAA940, 64'h0);

        run_block("rt_one", 128'h1, tea_enc(128'h1, 64'h1), 64'h1);

        // Constant time over extreme and random keys/data
        ct_keys[0] = '0;
        ct_keys[1] = '1;
        ct_keys[2] = rand_key();
        ct_data[0] = '0;
        ct_data[1] = '1;
        for (int i = 0; i < 3; i++) begin
            for (int j = 0; j < 2; j++) begin
                run_block("ctime", ct_keys[i], tea_enc(ct_keys[i], ct_data[j]), ct_data[j]);
            end
        end

        for (int i = 0; i < 100; i++) begin
            ka = rand_key();
            pa = {$urandom, $urandom};
            run_block("rt_rand", ka, tea_enc(ka, pa), pa);
        end

        // Backpressure in DONE
        ka = rand_key();
        pa = {$urandom, $urandom};
        i_axis_ready_m = 1'b0;
        accept(ka, tea_enc(ka, pa), 1'b0);
        wait_result(1'b0, lat, proc, seq_ok, busy_ok);
        check("bp_latency", 128'(lat), 128'd34);
        check("bp_data", 128'(o_axis_data_m), 128'(pa));
        held = o_axis_data_m;
        stable = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge i_clk);
            if (o_axis_valid_m !== 1'b1 || o_axis_data_m !== held || o_axis_ready_s !== 1'b0)
                stable = 1'b0;
        end
        check("bp_hold_stable", 128'(stable), 128'd1);
        i_axis_ready_m = 1'b1;
        @(negedge i_clk);
        check("bp_valid_drop", 128'(o_axis_valid_m), 128'd0);
        check("bp_idle", 128'(dut.state), 128'd0);
        check("bp_ready_s", 128'(o_axis_ready_s), 128'd1);

        // Input held while busy, key wiggling; second block taken only from IDLE
        ka = rand_key();
        kb = rand_key();
        pa = {$urandom, $urandom};
        pb = {$urandom, $urandom};
        accept(ka, tea_enc(ka, pa), 1'b1);
        i_axis_data_s = tea_enc(kb, pb);
        wait_result(1'b1, lat, proc, seq_ok, busy_ok);
        check("busy_ready_low", 128'(busy_ok), 128'd1);
        check("busy_latency", 128'(lat), 128'd34);
        check("busy_first_data", 128'(o_axis_data_m), 128'(pa));
        i_key = kb;
        @(negedge i_clk);
        check("busy_idle", 128'(dut.state), 128'd0);
        check("busy_idle_ready", 128'(o_axis_ready_s), 128'd1);
        check("busy_idle_valid_m", 128'(o_axis_valid_m), 128'd0);
        @(negedge i_clk);
        i_axis_valid_s = 1'b0;
        check("busy_second_loading", 128'(dut.state), 128'd1);
        wait_result(1'b0, lat, proc, seq_ok, busy_ok);
        check("busy_second_latency", 128'(lat), 128'd34);
        check("busy_second_data", 128'(o_axis_data_m), 128'(pb));
        @(negedge i_clk);

        // Reset during round 10 aborts the block
        accept(128'h0, 64'h41EA3A0A_94BAA940, 1'b0);
        for (int i = 0; i < 100; i++) begin
            if (dut.state === 2'd2 && dut.round_counter === 6'd10) break;
            @(negedge i_clk);
        end
        check("mid_round10", 128'(dut.round_counter), 128'd10);
        #2 i_rst_n = 1'b0;
        #1;
        check("mid_rst_valid_m", 128'(o_axis_valid_m), 128'd0);
        check("mid_rst_state", 128'(dut.state), 128'd0);
        check("mid_rst_ready_s", 128'(o_axis_ready_s), 128'd0);
        check("mid_rst_data_m", 128'(o_axis_data_m), 128'd0);
        @(negedge i_clk);
        @(negedge i_clk);
        i_rst_n = 1'b1;
        repeat (3) @(negedge i_clk);
        check("post_rst_ready_s", 128'(o_axis_ready_s), 128'd1);
        check("post_rst_valid_m", 128'(o_axis_valid_m), 128'd0);
        run_block("kat_after_rst", 128'h0, 64'h41EA3A0A_94BAA940, 64'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/tea_decryptor.md
Name: tea_decryptor

Overview:
- Inverse of the TEA encryption accelerator: accepts one 64-bit ciphertext block on an AXI-Stream slave port and decrypts it under a 128-bit key in exactly ROUNDS cycles, one round per cycle.
- Returns the 64-bit plaintext on an AXI-Stream master port.
- Sits on the receive side of the crypto datapath, directly opposite the encryptor; fixed, data-independent latency (constant time).

Parameters:
- ROUNDS, 32, number of TEA decryption rounds (must equal the encryptor's round count).
- DELTA, 32'h9E3779B9, TEA key-schedule constant.

Ports:
- i_clk  in  1  clock, rising edge
- i_rst_n  in  1  asynchronous active-low reset
- i_key  in  128  key: k0=[127:96], k1=[95:64], k2=[63:32], k3=[31:0]
- i_axis_valid_s  in  1  ciphertext valid
- o_axis_ready_s  out  1  ready to accept ciphertext
- i_axis_data_s  in  64  ciphertext: v0=[63:32], v1=[31:0]
- o_axis_valid_m  out  1  plaintext valid
- i_axis_ready_m  in  1  downstream ready
- o_axis_data_m  out  64  plaintext: v0=[63:32], v1=[31:0]

Behaviour:
- Reset (async assert, sync deassert inside the block):
  - state=IDLE, round_counter=0.
  - o_axis_ready_s=0 while i_rst_n low, then 1 from the first cycle in IDLE.
  - o_axis_valid_m=0, o_axis_data_m=0, internal v0/v1/sum/key registers=0.
- FSM, internal signals `state` and `round_counter`; encoding IDLE=2'd0, LOADING=2'd1, PROCESSING=2'd2, DONE=2'd3:
  - IDLE: o_axis_ready_s=1. When i_axis_valid_s=1, register i_axis_data_s into v0/v1 and i_key into the key register, then go to LOADING. Key changes after acceptance have no effect on the block in flight.
  - LOADING: one cycle. sum=DELTA*ROUNDS mod 2^32 (32'hC6EF3720 for defaults), round_counter=0, then go to PROCESSING.
  - PROCESSING: one round per cycle:
    - v1 -= ((v0<<4)+k2) ^ (v0+sum) ^ ((v0>>5)+k3)
    - v0 -= ((v1_new<<4)+k0) ^ (v1_new+sum) ^ ((v1_new>>5)+k1)
    - sum -= DELTA
    - round_counter += 1
    - After exactly ROUNDS cycles in PROCESSING go to DONE and load o_axis_data_m={v0,v1}.
  - DONE: o_axis_valid_m=1 and o_axis_data_m held stable until i_axis_ready_m=1. On that handshake edge, o_axis_valid_m drops to 0 and state returns to IDLE.
- Arithmetic: all adds and subtracts are modulo 2^32. Shifts are logical. round_counter width is $clog2(ROUNDS)+1 so it never wraps before the terminal count.
- Latency: handshake accepted at edge T → LOADING during cycle T+1, PROCESSING during T+2..T+ROUNDS+1, o_axis_valid_m=1 from T+ROUNDS+2 (34 cycles for defaults).
- Timing is independent of key and data values: no early exit, no data-dependent stalls.
- Backpressure: o_axis_ready_s=0 in LOADING, PROCESSING and DONE. A valid input presented then is not consumed and must be held by the source.
  - o_axis_valid_m never deasserts without a handshake.
  - o_axis_data_m does not change while o_axis_valid_m=1.
- No output skid buffer: back-to-back throughput is one block per ROUNDS+3 cycles minimum; the output handshake and input acceptance never occur in the same cycle.
- Reset mid-operation (any state) aborts the block: outputs go to reset values immediately and no partial plaintext is ever emitted.

Test Plan:
- Known-answer test: i_key=0, ciphertext 64'h41EA3A0A_94BAA940, i_axis_ready_m=1 → o_axis_data_m=64'h0 asserted exactly 34 cycles after acceptance.
- Round trip: key 128'h...0001, plaintext 64'h...0001 through the existing TEA encryption accelerator, then its output fed into tea_decryptor → output 64'h0000000000000001; repeat with random key/data (≥100 vectors), all must match.
- Constant time: keys 0, all-ones and random, data 0 and all-ones → state==PROCESSING for exactly 32 cycles every time; round_counter increments 0..31 by one per cycle; DONE only after 32 PROCESSING cycles.
- Backpressure: hold i_axis_ready_m=0 for 20 cycles in DONE → o_axis_valid_m stays 1, o_axis_data_m stable, o_axis_ready_s=0. Raise ready → one handshake, return to IDLE next cycle.
- Input while busy: assert i_axis_valid_s during PROCESSING with changing i_key → o_axis_ready_s=0, no new capture, result uses the originally latched key. The second block is accepted only after return to IDLE.
- Reset mid-PROCESSING: pull i_rst_n low at round 10 → o_axis_valid_m=0 and state=IDLE asynchronously. After release, a fresh KAT block completes correctly in 34 cycles.
